// File: rtl/main_fifo_ctrl_if.sv
// main_fifo_ctrl_if: control/status bundle between the FIFO controller and the FIFO subsystem.
interface main_fifo_ctrl_if #(
  parameter int N_VC     = 4,
  parameter int UMBRAL_W = 4,
  parameter int CNT_W    = 16
);
  logic                init;
  logic [UMBRAL_W-1:0] umbral_main_in;
  logic [UMBRAL_W-1:0] umbral_vc_in;
  logic                main_empty;
  logic                main_error;
  logic [N_VC-1:0]     vc_empty;
  logic [N_VC-1:0]     vc_almost_full;
  logic [N_VC-1:0]     vc_error;
  logic                fifo_init;
  logic [UMBRAL_W-1:0] umbral_main;
  logic [UMBRAL_W-1:0] umbral_vc;
  logic                main_rd_enable;
  logic                idle;
  logic                active;
  logic                error;
  logic [4:0]          state;
  logic [CNT_W-1:0]    pop_count;
  modport master (
    input  init, umbral_main_in, umbral_vc_in, main_empty, main_error, vc_empty, vc_almost_full, vc_error,
    output fifo_init, umbral_main, umbral_vc, main_rd_enable, idle, active, error, state, pop_count
  );
  modport slave (
    output init, umbral_main_in, umbral_vc_in, main_empty, main_error, vc_empty, vc_almost_full, vc_error,
    input  fifo_init, umbral_main, umbral_vc, main_rd_enable, idle, active, error, state, pop_count
  );
endinterface

// File: rtl/main_fifo_ctrl.sv
// main_fifo_ctrl: sequences init of the main/VC FIFO path, owns thresholds, gates main-FIFO pops.
module main_fifo_ctrl #(
  parameter int N_VC     = 4,
  parameter int UMBRAL_W = 4,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  main_fifo_ctrl_if.master bus
);
  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;
  state_t              r_state;
  logic [UMBRAL_W-1:0] r_umbral_main;
  logic [UMBRAL_W-1:0] r_umbral_vc;
  logic [CNT_W-1:0]    r_pop_count;
  logic                w_any_err;
  logic                w_all_empty;
  logic                w_rd_en;
  assign w_any_err   = bus.main_error | (|bus.vc_error);
  assign w_all_empty = bus.main_empty & (&bus.vc_empty);
  // Pops stop the same cycle any VC nears full, so nothing is popped into a full VC.
  assign w_rd_en     = (r_state == S_ACTIVE) & ~bus.main_empty & ~(|bus.vc_almost_full);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RESET;
      r_umbral_main <= '0;
      r_umbral_vc   <= '0;
      r_pop_count   <= '0;
    end else begin
      case (r_state)
        S_RESET:  r_state <= S_INIT;
        S_INIT:   r_state <= bus.init ? S_INIT : S_IDLE;
        S_IDLE, S_ACTIVE:
          r_state <= w_any_err ? S_ERROR : bus.init ? S_INIT : w_all_empty ? S_IDLE : S_ACTIVE;
        S_ERROR:  r_state <= bus.init ? S_INIT : S_ERROR;
        default:  r_state <= S_RESET;
      endcase
      if (r_state == S_INIT) begin
        r_umbral_main <= bus.umbral_main_in;
        r_umbral_vc   <= bus.umbral_vc_in;
      end
      r_pop_count <= (r_state == S_INIT) ? '0 :
                     (w_rd_en && r_pop_count != '1) ? r_pop_count + CNT_W'(1) : r_pop_count;
    end
  end
  assign bus.state          = r_state;
  assign bus.umbral_main    = r_umbral_main;
  assign bus.umbral_vc      = r_umbral_vc;
  assign bus.pop_count      = r_pop_count;
  assign bus.main_rd_enable = w_rd_en;
  assign bus.fifo_init      = (r_state == S_IDLE) | (r_state == S_ACTIVE) | (r_state == S_ERROR);
  assign bus.idle           = r_state == S_IDLE;
  assign bus.active         = r_state == S_ACTIVE;
  assign bus.error          = r_state == S_ERROR;
endmodule

// File: tb/tb_main_fifo_ctrl.sv
// tb_main_fifo_ctrl: scoreboard bench for main_fifo_ctrl, built with a 4-bit pop counter to reach saturation.
module tb_main_fifo_ctrl;
  localparam int N_VC = 4, UMBRAL_W = 4, CNT_W = 4;
  localparam logic [4:0] ST_RESET = 5'b00001, ST_INIT = 5'b00010, ST_IDLE = 5'b00100,
                         ST_ACTIVE = 5'b01000, ST_ERROR = 5'b10000;
  typedef struct {
    logic [4:0] s;
    logic       r;
    int         c;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  main_fifo_ctrl_if #(.N_VC(N_VC), .UMBRAL_W(UMBRAL_W), .CNT_W(CNT_W)) bus ();
  main_fifo_ctrl #(.N_VC(N_VC), .UMBRAL_W(UMBRAL_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Expected state/pop/count for the cycle just driven; status flags follow from the state.
  task automatic tick(input logic [4:0] es, input logic er, input int ec);
    exp_t e;
    sb_q.push_back('{s: es, r: er, c: ec});
    #1;
    e = sb_q.pop_front();
    chk("state", 32'(bus.state), 32'(e.s));
    chk("main_rd_enable", 32'(bus.main_rd_enable), 32'(e.r));
    chk("pop_count", 32'(bus.pop_count), 32'(e.c));
    chk("idle", 32'(bus.idle), 32'(e.s == ST_IDLE));
    chk("active", 32'(bus.active), 32'(e.s == ST_ACTIVE));
    chk("error", 32'(bus.error), 32'(e.s == ST_ERROR));
    chk("fifo_init", 32'(bus.fifo_init), 32'(e.s == ST_IDLE || e.s == ST_ACTIVE || e.s == ST_ERROR));
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0;
    bus.init = 1'b0;
    bus.umbral_main_in = 4'd3;
    bus.umbral_vc_in = 4'd1;
    bus.main_empty = 1'b1;
    bus.main_error = 1'b0;
    bus.vc_empty = '1;
    bus.vc_almost_full = '0;
    bus.vc_error = '0;
    repeat (3) @(negedge clk);
    tick(ST_RESET, 0, 0);
    chk("rst_umbral_main", 32'(bus.umbral_main), 0);
    chk("rst_umbral_vc", 32'(bus.umbral_vc), 0);
    reset = 1'b1;
    bus.init = 1'b1;
    tick(ST_RESET, 0, 0);
    tick(ST_INIT, 0, 0);
    tick(ST_INIT, 0, 0);
    chk("umbral_main_init", 32'(bus.umbral_main), 3);
    chk("umbral_vc_init", 32'(bus.umbral_vc), 1);
    bus.init = 1'b0;
    tick(ST_INIT, 0, 0);
    tick(ST_IDLE, 0, 0);
    bus.umbral_main_in = 4'd7;
    tick(ST_IDLE, 0, 0);
    tick(ST_IDLE, 0, 0);
    chk("umbral_main_hold", 32'(bus.umbral_main), 3);
    bus.main_empty = 1'b0;
    tick(ST_IDLE, 0, 0);
    for (int i = 0; i < 4; i++) tick(ST_ACTIVE, 1, i);
    bus.main_empty = 1'b1;
    tick(ST_ACTIVE, 0, 4);
    tick(ST_IDLE, 0, 4);
    bus.main_empty = 1'b0;
    tick(ST_IDLE, 0, 4);
    tick(ST_ACTIVE, 1, 4);
    bus.vc_almost_full = 4'b0100;
    for (int i = 0; i < 3; i++) tick(ST_ACTIVE, 0, 5);
    bus.vc_almost_full = '0;
    tick(ST_ACTIVE, 1, 5);
    tick(ST_ACTIVE, 1, 6);
    bus.vc_error = 4'b0100;
    tick(ST_ACTIVE, 1, 7);
    bus.vc_error = '0;
    tick(ST_ERROR, 0, 8);
    tick(ST_ERROR, 0, 8);
    bus.init = 1'b1;
    tick(ST_ERROR, 0, 8);
    tick(ST_INIT, 0, 8);
    tick(ST_INIT, 0, 0);
    chk("umbral_main_relatch", 32'(bus.umbral_main), 7);
    bus.init = 1'b0;
    tick(ST_INIT, 0, 0);
    bus.main_error = 1'b1;
    bus.init = 1'b1;
    tick(ST_IDLE, 0, 0);
    bus.main_error = 1'b0;
    tick(ST_ERROR, 0, 0);
    bus.init = 1'b0;
    tick(ST_INIT, 0, 0);
    bus.main_empty = 1'b1;
    bus.vc_empty = 4'b1110;
    tick(ST_IDLE, 0, 0);
    tick(ST_ACTIVE, 0, 0);
    bus.main_empty = 1'b0;
    bus.vc_almost_full = 4'b0001;
    tick(ST_ACTIVE, 0, 0);
    bus.vc_almost_full = '0;
    tick(ST_ACTIVE, 1, 0);
    for (int i = 0; i < 20; i++) tick(ST_ACTIVE, 1, (i + 1 > 15) ? 15 : i + 1);
    #2 reset = 1'b0;
    tick(ST_RESET, 0, 0);
    chk("async_umbral_main", 32'(bus.umbral_main), 0);
    chk("async_umbral_vc", 32'(bus.umbral_vc), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/main_fifo_ctrl.md
Name: main_fifo_ctrl

Overview:
- FSM controller for the transmit-layer FIFO subsystem: one main FIFO feeding N_VC virtual-channel FIFOs.
- Sequences reset/initialisation and owns the threshold (Umbral) registers programmed into the FIFOs.
- Gates main-FIFO pops on downstream back-pressure and tracks the idle/active/error status of the whole path.

Parameters:
N_VC, 4, number of downstream virtual-channel FIFOs
UMBRAL_W, 4, width of each threshold register
CNT_W, 16, width of the popped-word counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  initialisation request, active-high, level-sensitive
umbral_main_in  in  UMBRAL_W  main FIFO threshold to program
umbral_vc_in  in  UMBRAL_W  VC FIFO threshold to program
main_empty  in  1  main FIFO empty flag
main_error  in  1  main FIFO error flag
vc_empty  in  N_VC  per-VC FIFO empty flags
vc_almost_full  in  N_VC  per-VC almost-full flags
vc_error  in  N_VC  per-VC error flags
fifo_init  out  1  run enable to all FIFOs' init pin (0 holds FIFOs cleared)
umbral_main  out  UMBRAL_W  latched main threshold
umbral_vc  out  UMBRAL_W  latched VC threshold
main_rd_enable  out  1  pop strobe to main FIFO
idle  out  1  subsystem idle
active  out  1  subsystem moving data
error  out  1  sticky error status
state  out  5  one-hot state (RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000)
pop_count  out  CNT_W  number of main-FIFO pops since last INIT

Behaviour:
- Reset (reset==0, async): state=RESET.
  - fifo_init, umbral_main, umbral_vc, main_rd_enable, idle, active, error, pop_count all 0.
- Definitions:
  - any_err = main_error | OR(vc_error).
  - all_empty = main_empty & AND(vc_empty).
- Transitions, evaluated each rising edge, priority top-down:
  - RESET: next edge with reset==1 -> INIT.
  - INIT:
    - umbral_main<=umbral_main_in and umbral_vc<=umbral_vc_in every cycle; pop_count<=0.
    - Stay while init==1; init==0 -> IDLE.
  - IDLE / ACTIVE:
    - any_err -> ERROR.
    - else init==1 -> INIT.
    - else all_empty -> IDLE.
    - else -> ACTIVE.
  - ERROR: sticky. init==1 -> INIT; otherwise stay. any_err deassertion does not leave ERROR.
- Thresholds: hold their value outside INIT; input changes are ignored.
- Status outputs (Moore decode of state, combinational from the state register, no extra latency):
  - fifo_init=1 in IDLE, ACTIVE, ERROR; 0 in RESET, INIT.
  - idle=1 only in IDLE; active=1 only in ACTIVE; error=1 only in ERROR.
- Pop gating:
  - main_rd_enable = (state==ACTIVE) & ~main_empty & ~OR(vc_almost_full). Combinational, zero latency.
  - The main FIFO samples it on the same edge.
  - Forced 0 in every other state, including the first cycle of ERROR.
- pop_count:
  - Increments by 1 on each edge where main_rd_enable==1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset or while in INIT.
- Simultaneous events:
  - error and init both asserted in IDLE/ACTIVE -> ERROR; the next cycle, init still high -> INIT.
  - vc_almost_full rising in the same cycle main_empty falls -> no pop.
- Reset mid-operation: state, outputs and counter clear immediately, asynchronously. Thresholds return to 0.

Test Plan:
1. Reset low 3 cycles, release; init=1 for 2 cycles with umbral_main_in=3, umbral_vc_in=1, then init=0 -> states RESET→INIT→IDLE. umbral_main=3, umbral_vc=1, fifo_init rises on the IDLE entry edge, idle=1.
2. From IDLE: main_empty=0 for 5 cycles, vc_almost_full=0 -> ACTIVE one edge later. main_rd_enable=1 for the 4 ACTIVE cycles; pop_count=4. main_empty=1 and vc_empty all 1 -> IDLE.
3. In ACTIVE, main_empty=0: assert vc_almost_full=4'b0100 for 3 cycles -> main_rd_enable=0 for exactly those 3 cycles, active stays 1, pop_count frozen.
4. In ACTIVE, pulse vc_error[2] one cycle -> ERROR next edge, error=1, main_rd_enable=0. Error stays 1 after vc_error clears. init=1 -> INIT, pop_count=0, fifo_init=0.
5. Drive umbral_main_in=7 while in IDLE -> umbral_main unchanged. Force pop_count to saturate (CNT_W=4 build, 20 pops) -> pop_count holds 15.
6. Assert reset=0 mid-ACTIVE between clock edges -> all outputs 0 and state=00001 immediately, without waiting for a clock edge.
